// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type execution unit: instruction fields, functs, FSM states, ALU ops.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a. Optional shift instructions are enabled by defining RTYPE_SHIFT_EN.
package rtype_pkg;

    // Instruction word bit fields
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int SH_HI = 10;
    localparam int SH_LO = 6;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    // Funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
        ALU_AND, ALU_OR,   ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL,  ALU_SRA,
        ALU_SLLV, ALU_SRLV, ALU_SRAV,
        ALU_ILL
    } alu_op_t;

    // Map op/funct onto an ALU operation; anything unrecognised is ALU_ILL.
    function automatic alu_op_t decode_funct(input logic [5:0] op, input logic [5:0] funct);
        alu_op_t r;
        r = ALU_ILL;
        if (op == 6'd0) begin
            case (funct)
                F_ADD:   r = ALU_ADD;
                F_ADDU:  r = ALU_ADDU;
                F_SUB:   r = ALU_SUB;
                F_SUBU:  r = ALU_SUBU;
                F_AND:   r = ALU_AND;
                F_OR:    r = ALU_OR;
                F_XOR:   r = ALU_XOR;
                F_NOR:   r = ALU_NOR;
                F_SLT:   r = ALU_SLT;
                F_SLTU:  r = ALU_SLTU;
`ifdef RTYPE_SHIFT_EN
                F_SLL:   r = ALU_SLL;
                F_SRL:   r = ALU_SRL;
                F_SRA:   r = ALU_SRA;
                F_SLLV:  r = ALU_SLLV;
                F_SRLV:  r = ALU_SRLV;
                F_SRAV:  r = ALU_SRAV;
`endif
                default: r = ALU_ILL;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/rtype_regfile.sv
// Register file: 2 combinational read ports + debug read port, 1 synchronous write port, r0 hardwired to 0.
// Latency: reads are combinational; a write is visible the cycle after it is presented.
// Backpressure: none; addresses >= REG_N read 0 and writes to them are dropped.
module rtype_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        i_rs_addr,
    input  logic [4:0]        i_rt_addr,
    input  logic [4:0]        i_dbg_addr,
    input  logic              i_we,
    input  logic [4:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [DATA_W-1:0] o_dbg_data
);
    // Register 0 is not stored at all, so it cannot be written.
    logic [DATA_W-1:0] r_regs [1:REG_N-1];

    // Address decode by comparison keeps unimplemented addresses reading 0.
    function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 1; i < REG_N; i++) begin
            if (addr == 5'(i)) v = r_regs[i];
        end
        return v;
    endfunction

    assign o_rs_data  = read_reg(i_rs_addr);
    assign o_rt_data  = read_reg(i_rt_addr);
    assign o_dbg_data = read_reg(i_dbg_addr);

    // Register storage: cleared on reset, single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_N; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            for (int i = 1; i < REG_N; i++) begin
                if (i_wr_addr == 5'(i)) r_regs[i] <= i_wr_data;
            end
        end
    end

endmodule

// File: rtl/rtype_exec_unit.sv
// Multi-cycle MIPS R-type unit: IDLE -> READ -> EXEC -> WB, registered operands/result/flags. Macro RTYPE_SHIFT_EN adds shifts.
// Latency: accept in cycle N, done pulse (WB) in N+3; one instruction per 3 cycles when streaming.
// Backpressure: in_ready high only in IDLE and WB; overflowing or illegal instructions complete without writing.
module rtype_exec_unit
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       I,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              ovf,
    output logic              illegal,
    output logic              done,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_t            r_state, w_next;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_a, r_b, r_result;
    logic              r_zero, r_ovf, r_ill;
    logic              w_ready, w_done, w_accept, w_we;
    logic [DATA_W-1:0] w_rs_data, w_rt_data;
    logic [DATA_W-1:0] w_sum, w_diff, w_alu;
    logic              w_ovf, w_ill;
    logic [6:0]        w_shamt, w_vamt;
    alu_op_t           w_op;

    assign w_accept = in_valid && w_ready;
    // Overflowing or illegal results never reach the register file; rd 0 and rd >= REG_N are dropped inside it.
    assign w_we     = (r_state == S_WB) && !r_ovf && !r_ill;

    rtype_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rs_addr  (r_instr[RS_HI:RS_LO]),
        .i_rt_addr  (r_instr[RT_HI:RT_LO]),
        .i_dbg_addr (dbg_addr),
        .i_we       (w_we),
        .i_wr_addr  (r_instr[RD_HI:RD_LO]),
        .i_wr_data  (r_result),
        .o_rs_data  (w_rs_data),
        .o_rt_data  (w_rt_data),
        .o_dbg_data (dbg_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state, ready and done; WB can accept the next instruction directly.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (in_valid) w_next = S_READ;
            end
            S_READ: w_next = S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB: begin
                w_ready = 1'b1;
                w_done  = 1'b1;
                w_next  = in_valid ? S_READ : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_op    = decode_funct(r_instr[OP_HI:OP_LO], r_instr[FN_HI:FN_LO]);
    assign w_sum   = r_a + r_b;
    assign w_diff  = r_a - r_b;
    assign w_shamt = {2'b00, r_instr[SH_HI:SH_LO]} % 7'(DATA_W);
    assign w_vamt  = {2'b00, r_a[4:0]};

    // ALU: result and overflow for the decoded operation (shift ops only reachable when decoded).
    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_alu = w_sum;
                w_ovf = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
            end
            ALU_SUB: begin
                w_alu = w_diff;
                w_ovf = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);
            end
            ALU_ADDU: w_alu = w_sum;
            ALU_SUBU: w_alu = w_diff;
            ALU_AND:  w_alu = r_a & r_b;
            ALU_OR:   w_alu = r_a | r_b;
            ALU_XOR:  w_alu = r_a ^ r_b;
            ALU_NOR:  w_alu = ~(r_a | r_b);
            ALU_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(r_b));
            ALU_SLTU: w_alu = DATA_W'(r_a < r_b);
            ALU_SLL:  w_alu = r_b << w_shamt;
            ALU_SRL:  w_alu = r_b >> w_shamt;
            ALU_SRA:  w_alu = $signed(r_b) >>> w_shamt;
            ALU_SLLV: w_alu = r_b << w_vamt;
            ALU_SRLV: w_alu = r_b >> w_vamt;
            ALU_SRAV: w_alu = $signed(r_b) >>> w_vamt;
            default:  w_alu = '0;
        endcase
    end

    assign w_ill = (w_op == ALU_ILL);

    // Datapath registers: latch on accept, operands in READ, result and flags in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_instr <= I;
                r_ovf   <= 1'b0;
                r_ill   <= 1'b0;
            end
            if (r_state == S_READ) begin
                r_a <= w_rs_data;
                r_b <= w_rt_data;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu;
                r_zero   <= (w_alu == '0);
                r_ovf    <= w_ovf;
                r_ill    <= w_ill;
            end
        end
    end

    assign in_ready = w_ready;
    assign done     = w_done;
    assign A        = r_a;
    assign B        = r_b;
    assign result   = r_result;
    assign zero     = r_zero;
    assign ovf      = r_ovf;
    assign illegal  = r_ill;

endmodule

// File: tb/tb_rtype_exec_unit.sv
// Directed bench for rtype_exec_unit with an instruction-level reference model and per-cycle compare.
// Registers are preloaded by executing R-type sequences (nor/sltu to make 1, then addu doubling).
// Define RTYPE_SHIFT_EN for both bench and RTL to exercise the shift instructions.
module tb_rtype_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] I;
    logic [31:0] A, B, result, dbg_data;
    logic        zero, ovf, illegal, done;
    logic [4:0]  dbg_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtype_exec_unit #(.DATA_W(32), .REG_N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .I(I),
        .A(A), .B(B), .result(result), .zero(zero), .ovf(ovf), .illegal(illegal),
        .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] ins;
        int          cyc;
    } acc_t;

    logic [31:0] m_regs [32];
    acc_t        q [$];
    logic [31:0] exp_a, exp_b, exp_res;
    logic        exp_zero, exp_ovf, exp_ill, res_known;
    int          cyc = 0;
    int          last_acc = 0;
    int          prev_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction semantics straight from the ISA definition.
    function automatic void model_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] res, output logic ov, output logic il);
        longint sa, sb, s;
        sa  = $signed(a);
        sb  = $signed(b);
        s   = 0;
        res = 32'h0;
        ov  = 1'b0;
        il  = (ins[31:26] != 6'd0);
        case (ins[5:0])
            6'h20: begin s = sa + sb; res = a + b; ov = (s != longint'($signed(res))); end
            6'h21: res = a + b;
            6'h22: begin s = sa - sb; res = a - b; ov = (s != longint'($signed(res))); end
            6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h27: res = ~(a | b);
            6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: res = (a < b) ? 32'd1 : 32'd0;
`ifdef RTYPE_SHIFT_EN
            6'h00: res = b << ins[10:6];
            6'h02: res = b >> ins[10:6];
            6'h03: res = $signed(b) >>> ins[10:6];
            6'h04: res = b << a[4:0];
            6'h06: res = b >> a[4:0];
            6'h07: res = $signed(b) >>> a[4:0];
`endif
            default: il = 1'b1;
        endcase
        if (il) ov = 1'b0;
    endfunction

    // Compare process: every falling edge.
    always @(negedge clk) begin
        acc_t        e;
        logic [31:0] ra, rb, res;
        logic        ov, il;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            exp_a = 0; exp_b = 0; exp_res = 0;
            exp_zero = 1'b1; exp_ovf = 1'b0; exp_ill = 1'b0; res_known = 1'b1;
            chk("done_during_reset", done, 0);
        end else begin
            chk("dbg_data", dbg_data, m_regs[dbg_addr]);
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    e  = q.pop_front();
                    ra = m_regs[e.ins[25:21]];
                    rb = m_regs[e.ins[20:16]];
                    model_exec(e.ins, ra, rb, res, ov, il);
                    chk("latency", cyc - e.cyc, 3);
                    chk("A", A, ra);
                    chk("B", B, rb);
                    chk("ovf", ovf, ov);
                    chk("illegal", illegal, il);
                    exp_a = ra; exp_b = rb; exp_ovf = ov; exp_ill = il;
                    res_known = !il;
                    if (!il) begin
                        chk("result", result, res);
                        chk("zero", zero, res == 32'h0);
                        exp_res  = res;
                        exp_zero = (res == 32'h0);
                    end
                    if (!ov && !il && e.ins[15:11] != 5'd0) m_regs[e.ins[15:11]] = res;
                end
            end else if (q.size() == 0) begin
                chk("idle_ready", in_ready, 1);
                chk("idle_A", A, exp_a);
                chk("idle_B", B, exp_b);
                chk("idle_ovf", ovf, exp_ovf);
                chk("idle_illegal", illegal, exp_ill);
                if (res_known) begin
                    chk("idle_result", result, exp_res);
                    chk("idle_zero", zero, exp_zero);
                end
            end else begin
                chk("busy_ready", in_ready, 0);
            end
            if (in_valid && in_ready) begin
                e.ins = I;
                e.cyc = cyc;
                q.push_back(e);
                prev_acc = last_acc;
                last_acc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc(input logic [5:0] fn, input int rd, input int rs, input int rt, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    // Present an instruction and return at posedge+1 after it has been accepted.
    task automatic issue(input logic [31:0] ins);
        bit ok;
        ok       = 1'b0;
        I        = ins;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) chk("issue_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (in_ready && !done && q.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", {in_ready, done}, 2'b10);
        @(posedge clk);
        #1;
    endtask

    // Build an arbitrary constant in rd using r31 == 1.
    task automatic load(input int rd, input logic [31:0] v);
        bit started;
        started = 1'b0;
        issue(enc(6'h25, rd, 0, 0, 0));
        for (int i = 31; i >= 0; i--) begin
            if (started) issue(enc(6'h21, rd, rd, rd, 0));
            if (v[i]) begin
                issue(enc(6'h21, rd, rd, 31, 0));
                started = 1'b1;
            end
        end
    endtask

    task automatic peek(input int r, input logic [31:0] exp, input string name);
        dbg_addr = 5'(r);
        #1;
        chk(name, dbg_data, exp);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        I        = 32'h0;
        dbg_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // r30 = -1, r31 = 1
        issue(enc(6'h27, 30, 0, 0, 0));
        issue(enc(6'h2B, 31, 0, 30, 0));
        load(1, 32'd5);
        load(2, 32'd7);
        wait_idle();
        peek(31, 32'd1, "const_one");

        // Basic add r3,r1,r2
        issue(32'h0022_1820);
        wait_idle();
        chk("add_result", result, 32'd12);
        chk("add_zero", zero, 0);
        peek(3, 32'd12, "add_r3");

        // Back-to-back: add r3 then sub r4,r3,r1 reading the fresh r3
        issue(enc(6'h25, 3, 0, 0, 0));
        wait_idle();
        issue(32'h0022_1820);
        issue(enc(6'h22, 4, 3, 1, 0));
        wait_idle();
        chk("b2b_spacing", last_acc - prev_acc, 3);
        chk("b2b_result", result, 32'd7);
        peek(4, 32'd7, "b2b_r4");

        // Signed overflow
        load(1, 32'h7FFF_FFFF);
        load(2, 32'd1);
        issue(enc(6'h20, 3, 1, 2, 0));
        wait_idle();
        chk("add_ovf", ovf, 1);
        peek(3, 32'd12, "ovf_r3_kept");
        issue(enc(6'h21, 3, 1, 2, 0));
        wait_idle();
        chk("addu_ovf", ovf, 0);
        peek(3, 32'h8000_0000, "addu_r3");
        issue(enc(6'h22, 6, 3, 2, 0));
        wait_idle();
        chk("sub_ovf", ovf, 1);
        peek(6, 32'd0, "sub_ovf_r6_kept");

        // Illegal opcode and unknown funct; write to r0
        issue({6'h08, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20});
        wait_idle();
        chk("op_illegal", illegal, 1);
        peek(7, 32'd0, "illegal_r7_kept");
        issue(enc(6'h3F, 7, 1, 2, 0));
        wait_idle();
        chk("funct_illegal", illegal, 1);
        issue(enc(6'h25, 0, 1, 2, 0));
        wait_idle();
        chk("or_r0_legal", illegal, 0);
        peek(0, 32'd0, "r0_zero");

        // slt / sltu and logic ops with r1 = -1, r2 = 1
        issue(enc(6'h27, 1, 0, 0, 0));
        issue(enc(6'h2A, 8, 1, 2, 0));
        issue(enc(6'h2B, 9, 1, 2, 0));
        issue(enc(6'h26, 10, 1, 2, 0));
        issue(enc(6'h24, 11, 1, 2, 0));
        issue(enc(6'h23, 12, 0, 2, 0));
        wait_idle();
        peek(8, 32'd1, "slt");
        peek(9, 32'd0, "sltu");
        peek(10, 32'hFFFF_FFFE, "xor");
        peek(12, 32'hFFFF_FFFF, "subu");

        // Shifts
        load(2, 32'd7);
        issue(enc(6'h00, 5, 0, 2, 4));
        wait_idle();
`ifdef RTYPE_SHIFT_EN
        chk("sll_illegal", illegal, 0);
        peek(5, 32'h70, "sll_r5");
        issue(enc(6'h03, 13, 0, 1, 7));
        issue(enc(6'h06, 14, 2, 1, 0));
        wait_idle();
        peek(13, 32'hFFFF_FFFF, "sra");
        peek(14, 32'h01FF_FFFF, "srlv");
`else
        chk("sll_illegal", illegal, 1);
        peek(5, 32'd0, "sll_r5_kept");
`endif

        // Reset in the middle of EXEC
        issue(enc(6'h25, 15, 2, 31, 0));
        wait_idle();
        issue(enc(6'h20, 3, 2, 2, 0));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_zero", zero, 1);
        chk("midrst_done", done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", in_ready, 1);
        chk("postrst_done", done, 0);
        @(posedge clk);
        #1;
        peek(3, 32'd0, "postrst_r3");
        peek(15, 32'd0, "postrst_r15");
        repeat (4) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtype_exec_unit.md
# rtype_exec_unit

Parametrised multi-cycle execution unit for MIPS R-type instructions. It combines a 2-read/1-write register file, an ALU and funct decode behind a valid/ready instruction handshake. Each accepted instruction walks a READ → EXEC → WB state machine, with registered operands, result and flags. It is the successor to the single-cycle R-type datapath and adds overflow trapping, illegal-instruction detection and a debug read port for verification.

## Interface
- DATA_W, 32: datapath and register width; legal range 8..64.
- REG_N, 32: number of implemented registers; legal range 2..32. Addresses ≥ REG_N read 0, and writes to them are dropped.
- clk  in  1  single clock; every state element updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- in_valid  in  1  instruction word present.
- in_ready  out  1  unit can accept an instruction.
- I  in  32  instruction word (op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]).
- A, B  out  DATA_W  registered operands read from rs and rt.
- result  out  DATA_W  registered ALU result.
- zero  out  1  registered flag, set when result == 0.
- ovf  out  1  signed overflow on add/sub; sticky until the next accept.
- illegal  out  1  op ≠ 0 or unknown funct; sticky until the next accept.
- done  out  1  one-cycle pulse in WB.
- dbg_addr  in  5  debug register select.
- dbg_data  out  DATA_W  combinational read of register dbg_addr; register 0 always reads 0.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- Accept: a handshake completes when in_valid && in_ready. in_ready = 1 in IDLE and in WB, and 0 in READ and EXEC.
- On accept, the unit latches I, clears ovf and illegal, and moves to READ.
- WB without an accept → IDLE. WB with an accept → READ (back-to-back instructions).
- READ: A ← reg[rs], B ← reg[rt]. The read sees any write committed in the preceding WB, so no bypass is needed.
- EXEC: result ← ALU(A, B). zero, ovf and illegal are registered here.
- Funct map:
  - add 0x20 and sub 0x22: signed; overflow sets ovf.
  - addu 0x21 and subu 0x23: wrap modulo 2^DATA_W.
  - and 0x24, or 0x25, xor 0x26, nor 0x27.
  - slt 0x2A (signed, result 0/1) and sltu 0x2B (unsigned).
- Arithmetic is performed at DATA_W bits. Overflow means both operands have the same sign and the result sign differs (sub compares against the negated B).
- WB: reg[rd] ← result only when rd ≠ 0, rd < REG_N, ovf = 0 and illegal = 0. done = 1 for exactly this cycle.
- Illegal or overflowing instructions still pass through all three states and still pulse done, but they never modify the register file.
- Register 0 is hardwired to 0.

## Timing
- Latency: accept in cycle N gives READ in N+1, EXEC in N+2, WB (done) in N+3.
- Throughput: one instruction every 3 cycles when in_valid is held high.
- A, B, result and flags stay stable from their update until the next update. They remain stable through IDLE.
- Reset (asynchronous, at any point including mid-instruction):
  - FSM → IDLE.
  - All registers, A, B and result → 0.
  - zero → 1; ovf, illegal and done → 0.
  - in_ready → 1 once rst deasserts.
  - Any in-flight instruction is discarded with no write.
- A dbg_addr that is out of range reads 0.

## Configuration
- RTYPE_SHIFT_EN defined:
  - Adds sll 0x00, srl 0x02 and sra 0x03, operating on B with shift amount shamt (5 bits, taken modulo DATA_W).
  - Adds sllv 0x04, srlv 0x06 and srav 0x07, using A[4:0] as the shift amount.
- RTYPE_SHIFT_EN undefined: all six shift functs decode as illegal.

## Structure
- Package rtype_pkg holds:
  - funct localparams;
  - the FSM state enum;
  - the internal ALU-op enum;
  - the op/rs/rt/rd/shamt/funct bit-field constants.
- Sub-module rtype_regfile: parameters DATA_W and REG_N; 2 combinational read ports plus the debug port, 1 synchronous write port, asynchronous reset; register 0 hardwired to 0.
- ALU and decode stay inline in rtype_exec_unit.

## Test plan
- Reset value: assert rst mid-EXEC → next edge in IDLE, result = 0, zero = 1, done never pulses, reg[rd] unchanged.
- Basic add: preload r1 = 5, r2 = 7; I = 0x00221820 (add r3,r1,r2) → done 3 cycles after accept, result = 12, dbg r3 = 12.
- Signed overflow: r1 = 0x7FFFFFFF, r2 = 1, add r3 → ovf = 1, r3 unchanged. Same operands with addu → r3 = 0x80000000, ovf = 0.
- Back-to-back: stream sub r4,r3,r1 immediately after the add into r3 → second instruction reads r3 = 12, so r4 = 7; accepts exactly 3 cycles apart.
- Illegal and hardwired zero: op = 0x08 → illegal = 1, no write. Also or r0,r1,r2 → r0 stays 0. Also slt with r1 = −1, r2 = 1 → 1, and sltu with the same operands → 0.
- Shift configuration: sll r5,r2,4 → with RTYPE_SHIFT_EN defined, r5 = 0x70; without it, illegal = 1 and r5 unchanged.
